inst_prefetch_queue: RTL and testbench
======================================

// Module: inst_prefetch_queue
// PURPOSE
//  Fetch-ahead buffer between instruction memory and the IF stage. Issues
//  sequential requests on a request/grant, in-order-response memory port and
//  tags each request with its PC. Presents {pc, instruction} to IF in program
//  order. Squashes all queued and in-flight fetches on a taken branch/jal/jalr.
// PARAMETERS
//  PC_W     15  PC / instruction-address width
//  INST_W   32  instruction width
//  DEPTH    4   slot count, power of 2, >=2; bounds allocated slots plus outstanding requests
//  RESET_PC 0   first fetch address after reset
//  PC_STEP  4   address increment per fetch
// PORTS
//  clk          in  1       clock, rising edge
//  reset        in  1       asynchronous, active-high
//  redirect     in  1       taken branch/jal/jalr; squash and refetch
//  redirect_pc  in  PC_W    new fetch address, valid with redirect
//  imem_req     out 1       request valid
//  imem_addr    out PC_W    request address (= fetch_pc)
//  imem_gnt     in  1       request accepted this cycle (when imem_req=1)
//  imem_rvalid  in  1       response valid; responses return in request order
//  imem_rdata   in  INST_W  response instruction
//  deq_valid    out 1       head slot holds returned instruction
//  deq_ready    in  1       IF consumes head (pc_write)
//  deq_pc       out PC_W    PC of head instruction
//  deq_inst     out INST_W  head instruction
//  resp_err     out 1       sticky: unexpected rvalid seen
// BEHAVIOUR
//  State: fetch_pc, slot array {pc, inst, done}, head/tail/fill ptrs (clog2(DEPTH) bits,
//   natural wrap), alloc_cnt and drop_cnt (clog2(DEPTH)+1 bits), FSM {FETCH, DISCARD}.
//  Reset (async): fetch_pc=RESET_PC; ptrs, counts, done bits 0; FSM=FETCH; resp_err=0.
//   While reset=1: imem_req=0, deq_valid=0, deq_pc=0, deq_inst=0.
//  Issue: imem_req = FSM==FETCH && !redirect && alloc_cnt<DEPTH.
//   On imem_req&&imem_gnt: slot[tail].pc=fetch_pc, done=0; tail++; alloc_cnt++;
//   fetch_pc += PC_STEP (wraps modulo 2^PC_W).
//  Response (FETCH, no redirect): on imem_rvalid, slot[fill].inst=imem_rdata,
//   done=1; fill++. Response data never bypasses combinationally to deq.
//  Dequeue: deq_valid = slot[head].done && alloc_cnt>0 && !redirect;
//   deq_pc/deq_inst come from slot[head]. On deq_valid&&deq_ready: head++, alloc_cnt--.
//  Latency: gnt at cycle t, rvalid at t+L -> deq_valid at t+L+1 (min 2 cycles).
//  Throughput: 1 instr/cycle sustained when L+1 < DEPTH.
//  Issue, response and dequeue in the same cycle are all legal; alloc_cnt nets +1/0/-1.
//  Full: alloc_cnt==DEPTH -> imem_req=0; resumes the cycle after a dequeue.
//  Redirect (any state, highest priority): no issue, no dequeue that cycle;
//   all slots invalidated (head=tail=fill=0, alloc_cnt=0);
//   fetch_pc=redirect_pc; drop_cnt = outstanding - (imem_rvalid ? 1 : 0),
//   where outstanding = allocated slots with done=0. An rvalid in the redirect
//   cycle is discarded. FSM -> DISCARD if the new drop_cnt>0, else FETCH.
//  DISCARD: imem_req=0; each imem_rvalid discards data, drop_cnt--;
//   when drop_cnt reaches 0 -> FETCH (issue resumes next cycle).
//   A redirect in DISCARD reloads fetch_pc; drop_cnt decrements by 1 if rvalid that cycle.
//  Unexpected rvalid (FETCH with outstanding==0, or DISCARD with drop_cnt==0):
//   ignored, resp_err<=1 (sticky until reset).
//  Reset mid-operation: all state cleared immediately. Post-reset stray rvalid -> resp_err.
// TESTING
//  1. Reset, gnt=1, rvalid 1 cycle after gnt, deq_ready=1 -> deq_pc 0,4,8,12... one/cycle, inst matches.
//  2. deq_ready=0, gnt=1 -> exactly DEPTH(4) requests issued, then imem_req=0;
//     one dequeue -> exactly one new request.
//  3. Latency 3, 3 outstanding, redirect to 0x100 -> 3 rvalids dropped, no deq_valid;
//     next request addr 0x100; first deq_pc 0x100.
//  4. Redirect in same cycle as rvalid with 2 outstanding -> drop_cnt=1; only one more
//     response dropped.
//  5. Back-to-back redirects 0x40 then 0x80 -> only 0x80 stream dequeued; no stale instr.
//  6. rvalid with nothing outstanding -> resp_err=1, queue unchanged; assert reset mid-stream
//     -> outputs 0 immediately, refetch from RESET_PC.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches on an in-order
// request/grant memory port, tags each slot with its PC and hands
// {pc, inst} to IF in program order. A taken redirect squashes queued
// slots and discards responses for fetches already in flight.
module inst_prefetch_queue #(
   parameter int              PC_W     = 15,
   parameter int              INST_W   = 32,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              deq_valid,
   input  logic              deq_ready,
   output logic [PC_W-1:0]   deq_pc,
   output logic [INST_W-1:0] deq_inst,
   output logic              resp_err
);

   localparam int              AW      = $clog2(DEPTH);
   localparam int              CW      = AW + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [PC_W-1:0] STEP_C  = PC_W'(PC_STEP);

   typedef enum logic {
      ST_FETCH,
      ST_DISCARD
   } state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]     slot_pc_q   [DEPTH];
   logic [PC_W-1:0]     slot_pc_d   [DEPTH];
   logic [INST_W-1:0]   slot_inst_q [DEPTH];
   logic [INST_W-1:0]   slot_inst_d [DEPTH];
   logic [DEPTH-1:0]    slot_done_q, slot_done_d;
   logic [AW-1:0]       head_q, head_d;
   logic [AW-1:0]       tail_q, tail_d;
   logic [AW-1:0]       fill_q, fill_d;
   logic [CW-1:0]       alloc_cnt_q, alloc_cnt_d;
   logic [CW-1:0]       drop_cnt_q, drop_cnt_d;
   logic                resp_err_q, resp_err_d;

   logic [CW-1:0]       outstanding;
   logic [CW-1:0]       pend_cnt;
   logic                issue_go;
   logic                deq_go;

   // Slots between fill and tail are awaiting data; fill==tail is either
   // none or all of them, told apart by whether the queue is full and undone.
   always_comb begin
      if (tail_q == fill_q) begin
         outstanding = (alloc_cnt_q == DEPTH_C && !slot_done_q[fill_q]) ? DEPTH_C : '0;
      end else begin
         outstanding = {1'b0, AW'(tail_q - fill_q)};
      end
   end

   // Port outputs; everything is forced quiet while reset is held.
   always_comb begin
      imem_req  = !reset && state_q == ST_FETCH && !redirect && alloc_cnt_q < DEPTH_C;
      imem_addr = fetch_pc_q;
      deq_valid = !reset && !redirect && alloc_cnt_q != '0 && slot_done_q[head_q];
      deq_pc    = reset ? '0 : slot_pc_q[head_q];
      deq_inst  = reset ? '0 : slot_inst_q[head_q];
      resp_err  = resp_err_q;
      issue_go  = imem_req && imem_gnt;
      deq_go    = deq_valid && deq_ready;
   end

   // Next-state: redirect squash, discard countdown, or normal issue/fill/dequeue.
   always_comb begin
      // NOTE: every *_d starts as its *_q so no path through this block leaves
      // a signal unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      slot_pc_d   = slot_pc_q;
      slot_inst_d = slot_inst_q;
      slot_done_d = slot_done_q;
      head_d      = head_q;
      tail_d      = tail_q;
      fill_d      = fill_q;
      alloc_cnt_d = alloc_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      resp_err_d  = resp_err_q;
      pend_cnt    = '0;

      if (redirect) begin
         // In DISCARD the queue is empty, so in-flight fetches live in drop_cnt.
         pend_cnt = (state_q == ST_DISCARD) ? drop_cnt_q : outstanding;
         if (imem_rvalid) begin
            if (pend_cnt != '0) pend_cnt = pend_cnt - CW'(1);
            else                resp_err_d = 1'b1;
         end
         head_d      = '0;
         tail_d      = '0;
         fill_d      = '0;
         alloc_cnt_d = '0;
         slot_done_d = '0;
         fetch_pc_d  = redirect_pc;
         drop_cnt_d  = pend_cnt;
         state_d     = (pend_cnt != '0) ? ST_DISCARD : ST_FETCH;
      end else if (state_q == ST_DISCARD) begin
         if (imem_rvalid) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - CW'(1);
               if (drop_cnt_q == CW'(1)) state_d = ST_FETCH;
            end else begin
               resp_err_d = 1'b1;
               state_d    = ST_FETCH;
            end
         end
      end else begin
         if (issue_go) begin
            slot_pc_d[tail_q]   = fetch_pc_q;
            slot_done_d[tail_q] = 1'b0;
            tail_d              = tail_q + AW'(1);
            fetch_pc_d          = fetch_pc_q + STEP_C;
         end
         if (imem_rvalid) begin
            if (outstanding != '0) begin
               slot_inst_d[fill_q] = imem_rdata;
               slot_done_d[fill_q] = 1'b1;
               fill_d              = fill_q + AW'(1);
            end else begin
               resp_err_d = 1'b1;
            end
         end
         if (deq_go) head_d = head_q + AW'(1);
         if (issue_go && !deq_go)      alloc_cnt_d = alloc_cnt_q + CW'(1);
         else if (!issue_go && deq_go) alloc_cnt_d = alloc_cnt_q - CW'(1);
      end
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the values from before the edge, independent of block order.
      if (reset) begin
         state_q     <= ST_FETCH;
         fetch_pc_q  <= RESET_PC;
         slot_done_q <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         fill_q      <= '0;
         alloc_cnt_q <= '0;
         drop_cnt_q  <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         slot_done_q <= slot_done_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         fill_q      <= fill_d;
         alloc_cnt_q <= alloc_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         resp_err_q  <= resp_err_d;
      end
   end

   // Slot payload storage.
   always_ff @(posedge clk) begin
      // NOTE: payload arrays are not reset; a slot is only read once its done
      // bit (which is reset) marks it valid, so clearing them buys nothing.
      slot_pc_q   <= slot_pc_d;
      slot_inst_q <= slot_inst_d;
   end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: an in-order memory with
// programmable latency, a queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_prefetch_queue;

   localparam int PC_W   = 15;
   localparam int INST_W = 32;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              redirect;
   logic [PC_W-1:0]   redirect_pc;
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [INST_W-1:0] imem_rdata;
   logic              deq_valid;
   logic              deq_ready;
   logic [PC_W-1:0]   deq_pc;
   logic [INST_W-1:0] deq_inst;
   logic              resp_err;

   always #5 clk = ~clk;

   inst_prefetch_queue #(
      .PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC('0), .PC_STEP(4)
   ) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
      .deq_inst(deq_inst), .resp_err(resp_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: allocated slots in program order, plus discard count.
   typedef struct {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
      bit                done;
   } ent_t;
   ent_t            mq[$];
   logic [PC_W-1:0] m_fetch_pc;
   int              m_drop;
   bit              m_err;

   // Memory environment and logs.
   logic [PC_W-1:0] pend_addr[$];
   int              pend_rdy[$];
   logic [PC_W-1:0] gnt_log[$];
   logic [PC_W-1:0] deq_log[$];
   int              deq_cyc[$];
   int              cyc = 0;

   int              gnt_prob, rv_prob, rdy_prob, redir_prob, lat;
   bit              redir_now = 0;
   logic [PC_W-1:0] redir_target;
   bit              force_stray = 0;

   function automatic logic [INST_W-1:0] mem_f(input logic [PC_W-1:0] a);
      return {a, 2'b10, ~a};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_fetch_pc = '0;
      m_drop     = 0;
      m_err      = 0;
      pend_addr.delete();
      pend_rdy.delete();
      gnt_log.delete();
      deq_log.delete();
      deq_cyc.delete();
   endtask

   // Hold reset for two edges; mid=1 asserts it asynchronously mid-cycle.
   task automatic do_reset(input bit mid);
      if (mid) begin
         @(posedge clk);
         #2;
      end else begin
         @(negedge clk);
      end
      reset = 1'b1;
      #1;
      check("rst_imem_req", imem_req, 0);
      check("rst_deq_valid", deq_valid, 0);
      check("rst_deq_pc", deq_pc, 0);
      check("rst_deq_inst", deq_inst, 0);
      check("rst_resp_err", resp_err, 0);
      redirect = 0; redirect_pc = '0; imem_gnt = 0; imem_rvalid = 0;
      imem_rdata = '0; deq_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // One clock: drive inputs, compare against the model, advance the model.
   task automatic step();
      bit              rv;
      logic [INST_W-1:0] rd;
      logic [PC_W-1:0] rpc;
      bit              e_req, e_dv;
      int              outst, fi, pend;
      ent_t            e;
      @(negedge clk);
      rv = 0;
      rd = $urandom;
      if (force_stray) begin
         rv = 1;
         force_stray = 0;
      end else if (pend_addr.size() > 0 && pend_rdy[0] <= cyc &&
                   $urandom_range(99) < rv_prob) begin
         rv = 1;
         rd = mem_f(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_rdy.pop_front());
      end
      rpc = PC_W'($urandom);
      rpc[1:0] = 2'b00;
      imem_rvalid = rv;
      imem_rdata  = rd;
      imem_gnt    = ($urandom_range(99) < gnt_prob);
      deq_ready   = ($urandom_range(99) < rdy_prob);
      redirect    = redir_now || ($urandom_range(99) < redir_prob);
      redirect_pc = redir_now ? redir_target : rpc;
      redir_now   = 0;
      #1;
      outst = 0;
      foreach (mq[i]) if (!mq[i].done) outst++;
      e_req = (m_drop == 0) && !redirect && (mq.size() < DEPTH);
      e_dv  = !redirect && mq.size() > 0 && mq[0].done;
      check("imem_req", imem_req, e_req);
      if (e_req) check("imem_addr", imem_addr, m_fetch_pc);
      check("deq_valid", deq_valid, e_dv);
      if (e_dv) begin
         check("deq_pc", deq_pc, mq[0].pc);
         check("deq_inst", deq_inst, mq[0].inst);
      end
      check("resp_err", resp_err, m_err);
      if (imem_req && imem_gnt) begin
         pend_addr.push_back(imem_addr);
         pend_rdy.push_back(cyc + lat);
         gnt_log.push_back(imem_addr);
      end
      if (deq_valid && deq_ready) begin
         deq_log.push_back(deq_pc);
         deq_cyc.push_back(cyc);
      end
      if (redirect) begin
         pend = (m_drop > 0) ? m_drop : outst;
         if (rv) begin
            if (pend > 0) pend--;
            else          m_err = 1;
         end
         m_drop = pend;
         mq.delete();
         m_fetch_pc = redirect_pc;
      end else if (m_drop > 0) begin
         if (rv) m_drop--;
      end else begin
         if (rv) begin
            fi = -1;
            foreach (mq[i]) if (!mq[i].done && fi < 0) fi = i;
            if (fi >= 0) begin
               mq[fi].inst = rd;
               mq[fi].done = 1;
            end else begin
               m_err = 1;
            end
         end
         if (e_dv && deq_ready) void'(mq.pop_front());
         if (e_req && imem_gnt) begin
            e.pc   = m_fetch_pc;
            e.inst = '0;
            e.done = 0;
            mq.push_back(e);
            m_fetch_pc = m_fetch_pc + PC_W'(4);
         end
      end
      cyc++;
   endtask

   task automatic knobs(input int g, input int r, input int d, input int l);
      gnt_prob = g; rv_prob = r; rdy_prob = d; lat = l; redir_prob = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1;
      redirect = 0; redirect_pc = '0; imem_gnt = 0; imem_rvalid = 0;
      imem_rdata = '0; deq_ready = 0;
      knobs(0, 0, 0, 1);

      // 1: streaming, latency 1, one instruction per cycle from PC 0.
      do_reset(0);
      knobs(100, 100, 100, 1);
      repeat (12) step();
      check("t1_first_addr", gnt_log.size() > 0 ? gnt_log[0] : 15'h7fff, 0);
      check("t1_ndeq", deq_log.size() >= 6, 1);
      for (int i = 0; i < 6; i++)
         if (i < deq_log.size()) check("t1_deq_pc", deq_log[i], 4 * i);
      if (deq_cyc.size() >= 6) check("t1_rate", deq_cyc[5] - deq_cyc[0], 5);

      // 2: consumer stalled, queue fills at DEPTH; one pop frees one request.
      do_reset(0);
      knobs(100, 100, 0, 1);
      repeat (10) step();
      check("t2_grants", gnt_log.size(), 4);
      check("t2_full_req", imem_req, 0);
      rdy_prob = 100;
      step();
      rdy_prob = 0;
      check("t2_one_deq", deq_log.size(), 1);
      repeat (5) step();
      check("t2_refill", gnt_log.size(), 5);

      // 3: three in flight at latency 3, redirect to 0x100.
      do_reset(0);
      knobs(100, 0, 100, 3);
      repeat (3) step();
      gnt_prob = 0;
      redir_now = 1; redir_target = 15'h100;
      step();
      check("t3_grants", gnt_log.size(), 3);
      knobs(100, 100, 100, 3);
      repeat (3) step();
      check("t3_no_deq", deq_log.size(), 0);
      check("t3_no_req", gnt_log.size(), 3);
      repeat (10) step();
      check("t3_next_addr", gnt_log.size() > 3 ? gnt_log[3] : 15'h7fff, 15'h100);
      check("t3_first_deq", deq_log.size() > 0 ? deq_log[0] : 15'h7fff, 15'h100);

      // 4: redirect coinciding with an rvalid, two outstanding -> drop one more.
      do_reset(0);
      knobs(100, 0, 100, 2);
      repeat (2) step();
      knobs(0, 100, 100, 2);
      redir_now = 1; redir_target = 15'h200;
      step();
      step();
      check("t4_discard_req", imem_req, 0);
      gnt_prob = 100;
      step();
      check("t4_resume_req", imem_req, 1);
      check("t4_resume_addr", imem_addr, 15'h200);
      repeat (6) step();
      check("t4_first_deq", deq_log.size() > 0 ? deq_log[0] : 15'h7fff, 15'h200);
      check("t4_err", resp_err, 0);

      // 5: back-to-back redirects; only the second stream reaches IF.
      do_reset(0);
      knobs(100, 100, 100, 2);
      repeat (6) step();
      redir_now = 1; redir_target = 15'h40;
      step();
      redir_now = 1; redir_target = 15'h80;
      step();
      n = deq_log.size();
      repeat (12) step();
      for (int i = 0; i < 3; i++)
         check("t5_deq_pc", (n + i) < deq_log.size() ? deq_log[n + i] : 15'h7fff, 15'h80 + 4 * i);

      // 6: stray response, then asynchronous reset mid-stream.
      do_reset(0);
      knobs(0, 0, 100, 1);
      repeat (3) step();
      force_stray = 1;
      step();
      step();
      check("t6_err", resp_err, 1);
      check("t6_no_deq", deq_valid, 0);
      knobs(100, 100, 100, 1);
      repeat (5) step();
      do_reset(1);
      step();
      check("t6_refetch", gnt_log.size() > 0 ? gnt_log[0] : 15'h7fff, 0);
      knobs(0, 100, 100, 1);
      repeat (4) step();
      force_stray = 1;
      step();
      step();
      check("t6_post_rst_err", resp_err, 1);

      // Randomized traffic with redirects, strays and periodic resets.
      do_reset(0);
      for (int k = 0; k < 4000; k++) begin
         if (k % 50 == 0) begin
            gnt_prob   = $urandom_range(100, 20);
            rv_prob    = $urandom_range(100, 30);
            rdy_prob   = $urandom_range(100, 20);
            redir_prob = $urandom_range(5, 0);
            lat        = $urandom_range(4, 1);
         end
         if (pend_addr.size() == 0 && $urandom_range(299) == 0) force_stray = 1;
         if (k % 1000 == 999) do_reset(1);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
